spi_slave: RTL

//  Serial front end of the SPI slave / single-port RAM subsystem. Deserialises MOSI frames into
//  10-bit words {cmd[1:0], payload[7:0]} for the RAM (rx_data/rx_valid). Serialises the RAM's
//  8-bit read data (tx_data/tx_valid) onto MISO. Single clock domain: SPI clock == clk.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_slave_if.sv | 35 +++
 rtl/spi_tx_serializer.sv | 48 ++++
 rtl/spi_slave.sv | 113 +++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end and its RAM-side peers.
package spi_pkg;

    localparam int unsigned FRAME_W_DFLT = 10;
    localparam int unsigned DATA_W_DFLT  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StChkCmd,
        StWrite,
        StReadAdd,
        StReadData
    } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// Serial pins plus RAM-side frame/read-data handshake of the SPI slave.
// SPI_FRAME_ERR_EN adds the frame_err abort strobe.
interface spi_slave_if import spi_pkg::*; #(
    parameter int unsigned FRAME_W = FRAME_W_DFLT,
    parameter int unsigned DATA_W  = DATA_W_DFLT
);

    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;
`ifdef SPI_FRAME_ERR_EN
    logic               frame_err;
`endif

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
`ifdef SPI_FRAME_ERR_EN
        output frame_err,
`endif
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
`ifdef SPI_FRAME_ERR_EN
        input  frame_err,
`endif
        input  MISO, rx_data, rx_valid
    );

endinterface

// File: rtl/spi_tx_serializer.sv
// MSB-first parallel-to-serial shifter for RAM read data; busy while bits remain,
// done once the last bit has been driven. DATA_W must be at least 2.
module spi_tx_serializer import spi_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              sout,
    output logic              busy,
    output logic              done
);

    localparam int unsigned RemW = $clog2(DATA_W);

    logic [DATA_W-1:0] shreg_q;
    logic [RemW-1:0]   remaining_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shreg_q     <= '0;
            remaining_q <= '0;
            sout        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (load) begin
            // MSB goes out immediately; the rest follow one per cycle.
            shreg_q     <= data << 1;
            sout        <= data[DATA_W-1];
            remaining_q <= RemW'(DATA_W - 1);
            busy        <= 1'b1;
            done        <= 1'b0;
        end else if (busy) begin
            if (remaining_q != '0) begin
                sout        <= shreg_q[DATA_W-1];
                shreg_q     <= shreg_q << 1;
                remaining_q <= remaining_q - 1'b1;
            end else begin
                sout <= 1'b0;
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end: MOSI frame deserialiser, command FSM and MISO read-data path.
// Define SPI_FRAME_ERR_EN to add the frame_err abort pulse on the interface.
module spi_slave import spi_pkg::*; #(
    parameter int unsigned FRAME_W = FRAME_W_DFLT,
    parameter int unsigned DATA_W  = DATA_W_DFLT
) (
    input logic        clk,
    input logic        rst_n,
    spi_slave_if.slave bus
);

    // bit_cnt counts received bits; FRAME_W+1 marks "frame delivered, ignore the rest".
    localparam int unsigned     CntW    = $clog2(FRAME_W + 2);
    localparam logic [CntW-1:0] CntFull = CntW'(FRAME_W);
    localparam logic [CntW-1:0] CntDone = CntW'(FRAME_W + 1);

    spi_state_e         state_q;
    logic [CntW-1:0]    bit_cnt_q;
    logic [FRAME_W-1:0] shreg_q;
    logic [FRAME_W-1:0] rx_data_q;
    logic               rx_valid_q;
    logic               rd_addr_seen_q;

    logic tx_load;
    logic tx_sout;
    logic tx_busy;
    logic tx_done;

    // Read data is accepted once, only after the READ_DATA frame has been delivered.
    assign tx_load = !bus.SS_n && (state_q == StReadData) && (bit_cnt_q == CntDone) &&
                     bus.tx_valid && !tx_busy && !tx_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            bit_cnt_q      <= '0;
            shreg_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (bus.SS_n) begin
                state_q   <= StIdle;
                bit_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q   <= StChkCmd;
                        bit_cnt_q <= '0;
                    end
                    StChkCmd: begin
                        shreg_q   <= {shreg_q[FRAME_W-2:0], bus.MOSI};
                        bit_cnt_q <= CntW'(1);
                        if (!bus.MOSI)          state_q <= StWrite;
                        else if (rd_addr_seen_q) state_q <= StReadData;
                        else                    state_q <= StReadAdd;
                    end
                    StWrite, StReadAdd, StReadData: begin
                        if (bit_cnt_q < CntFull) begin
                            shreg_q   <= {shreg_q[FRAME_W-2:0], bus.MOSI};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end else if (bit_cnt_q == CntFull) begin
                            rx_data_q  <= shreg_q;
                            rx_valid_q <= 1'b1;
                            bit_cnt_q  <= CntDone;
                            if (state_q == StReadAdd)  rd_addr_seen_q <= 1'b1;
                            if (state_q == StReadData) rd_addr_seen_q <= 1'b0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    spi_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (bus.SS_n),
        .load  (tx_load),
        .data  (bus.tx_data),
        .sout  (tx_sout),
        .busy  (tx_busy),
        .done  (tx_done)
    );

    assign bus.MISO     = tx_sout;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

`ifdef SPI_FRAME_ERR_EN
    logic frame_err_q;
    logic in_payload;

    assign in_payload = (state_q == StWrite) || (state_q == StReadAdd) ||
                        (state_q == StReadData);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= bus.SS_n && in_payload &&
                           ((bit_cnt_q < CntFull) || ((state_q == StReadData) && !tx_done));
        end
    end

    assign bus.frame_err = frame_err_q;
`endif

endmodule
